// File: rtl/yuv_pack_pkg.sv
// Shared definitions for the YUV 4:2:2 / 4:4:4 output packer.
//   pack_mode_e      : output packing mode (MODE_422 / MODE_444)
//   SYNC_DLY_DEFAULT : default sync-to-data lead of the colour-space converter
//   bar_color()      : 75% colour bar Y/Cb/Cr, BT.601 limited range, 8-bit
package yuv_pack_pkg;

  typedef enum logic {
    MODE_422 = 1'b0,
    MODE_444 = 1'b1
  } pack_mode_e;

  localparam int unsigned SYNC_DLY_DEFAULT = 6;
  localparam int unsigned NUM_BARS         = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } bar_ycc_t;

  // Order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic bar_ycc_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{y: 8'd180, cb: 8'd128, cr: 8'd128};
      3'd1:    return '{y: 8'd162, cb: 8'd44,  cr: 8'd142};
      3'd2:    return '{y: 8'd131, cb: 8'd156, cr: 8'd44};
      3'd3:    return '{y: 8'd112, cb: 8'd72,  cr: 8'd58};
      3'd4:    return '{y: 8'd84,  cb: 8'd184, cr: 8'd198};
      3'd5:    return '{y: 8'd65,  cb: 8'd100, cr: 8'd212};
      3'd6:    return '{y: 8'd35,  cb: 8'd212, cr: 8'd114};
      default: return '{y: 8'd16,  cb: 8'd128, cr: 8'd128};
    endcase
  endfunction

endpackage

// File: rtl/chroma_422_resampler.sv
// Chroma 4:2:2 resampler for one lane group: stage A capture, stage B pack.
// Ports:
//   i_clk, w_sysclk_arstn : clock, async active-low reset
//   i_avg                 : 1 = average chroma pairs, 0 = drop
//   i_de, i_y/i_u/i_v     : input pixels (pixel 0 in LSBs)
//   o_de, o_y/o_u/o_v     : stage B pixel, 4:4:4 passthrough
//   o_c                   : stage B 4:2:2 chroma per lane (Cb on even, Cr on odd)
module chroma_422_resampler
  import yuv_pack_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned PPC = 1
) (
  input  logic              i_clk,
  input  logic              w_sysclk_arstn,
  input  logic              i_avg,
  input  logic              i_de,
  input  logic [PPC*DW-1:0] i_y,
  input  logic [PPC*DW-1:0] i_u,
  input  logic [PPC*DW-1:0] i_v,
  output logic              o_de,
  output logic [PPC*DW-1:0] o_y,
  output logic [PPC*DW-1:0] o_u,
  output logic [PPC*DW-1:0] o_v,
  output logic [PPC*DW-1:0] o_c
);

  logic              ph_q;
  logic              a_de_q, a_ph_q;
  logic [PPC*DW-1:0] a_y_q, a_u_q, a_v_q;
  logic              b_de_q;
  logic [PPC*DW-1:0] b_y_q, b_u_q, b_v_q, b_c_q;
  logic [PPC*DW-1:0] c_d;
  logic [DW-1:0]     cr_hold_q;

  // Rounded mean computed one bit wider, then truncated.
  function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, 1'b1};
    return s[DW:1];
  endfunction

  if (PPC == 1) begin : g_ppc1
    // Even pixel in stage A looks ahead at the input: a valid input is its odd
    // partner (phase restarts on every de gap); otherwise it is unpaired.
    always_comb begin
      c_d = a_u_q;
      if (a_ph_q) begin
        c_d = i_avg ? avg2(cr_hold_q, a_v_q) : a_v_q;
      end else if (i_avg && i_de) begin
        c_d = avg2(a_u_q, i_u);
      end
    end
  end else begin : g_ppc2
    // Both pixels of a pair arrive together.
    always_comb begin
      c_d = '0;
      c_d[DW-1:0]    = i_avg ? avg2(a_u_q[DW-1:0], a_u_q[2*DW-1:DW]) : a_u_q[DW-1:0];
      c_d[2*DW-1:DW] = i_avg ? avg2(a_v_q[DW-1:0], a_v_q[2*DW-1:DW]) : a_v_q[2*DW-1:DW];
    end
  end

  always_ff @(posedge i_clk or negedge w_sysclk_arstn) begin
    if (!w_sysclk_arstn) begin
      ph_q      <= 1'b0;
      a_de_q    <= 1'b0;
      a_ph_q    <= 1'b0;
      a_y_q     <= '0;
      a_u_q     <= '0;
      a_v_q     <= '0;
      cr_hold_q <= '0;
      b_de_q    <= 1'b0;
      b_y_q     <= '0;
      b_u_q     <= '0;
      b_v_q     <= '0;
      b_c_q     <= '0;
    end else begin
      ph_q   <= i_de ? ~ph_q : 1'b0;
      a_de_q <= i_de;
      a_ph_q <= ph_q;
      a_y_q  <= i_y;
      a_u_q  <= i_u;
      a_v_q  <= i_v;
      // Even pixel's Cr is kept for the odd pixel's average.
      if (a_de_q && !a_ph_q) begin
        cr_hold_q <= a_v_q[DW-1:0];
      end
      b_de_q <= a_de_q;
      b_y_q  <= a_y_q;
      b_u_q  <= a_u_q;
      b_v_q  <= a_v_q;
      b_c_q  <= c_d;
    end
  end

  assign o_de = b_de_q;
  assign o_y  = b_y_q;
  assign o_u  = b_u_q;
  assign o_v  = b_v_q;
  assign o_c  = b_c_q;

endmodule

// File: rtl/yuv422_pack_pipe.sv
// HDMI output packer: YCbCr 4:4:4 in, 4:2:2 or 4:4:4 words out, sync
// re-alignment, output sync polarity, frame counter and LED heartbeat.
// Optional macro YUV_PACK_TPG_EN adds i_tpg_en / BAR_W and a 75% colour bar
// generator replacing the input pixels.
// Ports:
//   i_clk, w_sysclk_arstn      : pixel clock, async active-low reset
//   i_vs, i_hs                 : active-high syncs leading data by SYNC_DLY
//   i_de, i_y, i_u, i_v        : converter pixels, pixel 0 in LSBs
//   i_mode, i_chroma_avg       : 4:2:2/4:4:4, drop/average; latched on i_vs rise
//   o_vs, o_hs, o_de, o_data   : aligned syncs and packed pixels
//   o_frame_cnt, o_led         : completed frames, heartbeat bit
module yuv422_pack_pipe
  import yuv_pack_pkg::*;
#(
  parameter int unsigned DW           = 8,
  parameter int unsigned PPC          = 1,
  parameter int unsigned SYNC_DLY     = SYNC_DLY_DEFAULT,
  parameter bit          OUT_SYNC_INV = 1'b1,
  parameter int unsigned FCNT_W       = 12,
  parameter int unsigned LED_BIT      = 6
`ifdef YUV_PACK_TPG_EN
  ,
  parameter int unsigned BAR_W        = 240
`endif
) (
  input  logic                i_clk,
  input  logic                w_sysclk_arstn,
`ifdef YUV_PACK_TPG_EN
  input  logic                i_tpg_en,
`endif
  input  logic                i_vs,
  input  logic                i_hs,
  input  logic                i_de,
  input  logic [PPC*DW-1:0]   i_y,
  input  logic [PPC*DW-1:0]   i_u,
  input  logic [PPC*DW-1:0]   i_v,
  input  logic                i_mode,
  input  logic                i_chroma_avg,
  output logic                o_vs,
  output logic                o_hs,
  output logic                o_de,
  output logic [PPC*3*DW-1:0] o_data,
  output logic [FCNT_W-1:0]   o_frame_cnt,
  output logic                o_led
);

  localparam int unsigned SyncLen = SYNC_DLY + 3;

  logic [SyncLen-1:0] vs_sr_q, hs_sr_q;
  logic               vs_prev_q, vs_int_prev_q, armed_q, avg_q;
  pack_mode_e         mode_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic               out_de_q;
  logic [PPC*3*DW-1:0] out_data_q, data_d;
  logic               vs_rise, vs_int, de_in;
  logic [PPC*DW-1:0]  y_in, u_in, v_in;
  logic               b_de;
  logic [PPC*DW-1:0]  b_y, b_u, b_v, b_c;

  assign vs_rise = i_vs & ~vs_prev_q;
  assign vs_int  = vs_sr_q[SyncLen-1];
  // Nothing enters the pipe until a frame start has been seen after reset.
  assign de_in   = i_de & armed_q;

`ifdef YUV_PACK_TPG_EN
  logic       tpg_q;
  logic [15:0] bar_pos_q;
  logic [2:0] bar_idx_q;
  bar_ycc_t   bar;
  logic [DW-1:0] tpg_y, tpg_u, tpg_v;

  // Bar index advances every BAR_W pixels (BAR_W assumed a multiple of PPC)
  // and saturates on the last bar.
  always_ff @(posedge i_clk or negedge w_sysclk_arstn) begin
    if (!w_sysclk_arstn) begin
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else if (!i_de) begin
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else if (32'(bar_pos_q) + PPC >= BAR_W) begin
      bar_pos_q <= '0;
      if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 3'd1;
    end else begin
      bar_pos_q <= bar_pos_q + 16'(PPC);
    end
  end

  assign bar   = bar_color(bar_idx_q);
  assign tpg_y = DW'(bar.y) << (DW - 8);
  assign tpg_u = DW'(bar.cb) << (DW - 8);
  assign tpg_v = DW'(bar.cr) << (DW - 8);
  assign y_in  = tpg_q ? {PPC{tpg_y}} : i_y;
  assign u_in  = tpg_q ? {PPC{tpg_u}} : i_u;
  assign v_in  = tpg_q ? {PPC{tpg_v}} : i_v;
`else
  assign y_in = i_y;
  assign u_in = i_u;
  assign v_in = i_v;
`endif

  // Frame-level controls only change at a frame start.
  always_ff @(posedge i_clk or negedge w_sysclk_arstn) begin
    if (!w_sysclk_arstn) begin
      vs_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      mode_q    <= MODE_422;
      avg_q     <= 1'b0;
`ifdef YUV_PACK_TPG_EN
      tpg_q     <= 1'b0;
`endif
    end else begin
      vs_prev_q <= i_vs;
      if (vs_rise) begin
        armed_q <= 1'b1;
        mode_q  <= pack_mode_e'(i_mode);
        avg_q   <= i_chroma_avg;
`ifdef YUV_PACK_TPG_EN
        tpg_q   <= i_tpg_en;
`endif
      end
    end
  end

  chroma_422_resampler #(
    .DW  (DW),
    .PPC (PPC)
  ) u_resampler (
    .i_clk          (i_clk),
    .w_sysclk_arstn (w_sysclk_arstn),
    .i_avg          (avg_q),
    .i_de           (de_in),
    .i_y            (y_in),
    .i_u            (u_in),
    .i_v            (v_in),
    .o_de           (b_de),
    .o_y            (b_y),
    .o_u            (b_u),
    .o_v            (b_v),
    .o_c            (b_c)
  );

  always_comb begin
    data_d = '0;
    if (b_de) begin
      for (int p = 0; p < PPC; p++) begin
        if (mode_q == MODE_444) begin
          data_d[p*3*DW +: 3*DW] = {b_v[p*DW +: DW], b_u[p*DW +: DW], b_y[p*DW +: DW]};
        end else begin
          data_d[p*2*DW +: 2*DW] = {b_c[p*DW +: DW], b_y[p*DW +: DW]};
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge w_sysclk_arstn) begin
    if (!w_sysclk_arstn) begin
      vs_sr_q       <= '0;
      hs_sr_q       <= '0;
      vs_int_prev_q <= 1'b0;
      fcnt_q        <= '0;
      out_de_q      <= 1'b0;
      out_data_q    <= '0;
    end else begin
      vs_sr_q       <= {vs_sr_q[SyncLen-2:0], i_vs};
      hs_sr_q       <= {hs_sr_q[SyncLen-2:0], i_hs};
      vs_int_prev_q <= vs_int;
      if (vs_int_prev_q && !vs_int) begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
      out_de_q   <= b_de;
      out_data_q <= data_d;
    end
  end

  assign o_vs        = vs_int ^ OUT_SYNC_INV;
  assign o_hs        = hs_sr_q[SyncLen-1] ^ OUT_SYNC_INV;
  assign o_de        = out_de_q;
  assign o_data      = out_data_q;
  assign o_frame_cnt = fcnt_q;
  assign o_led       = fcnt_q[LED_BIT];

endmodule
